// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
package rv32i_types;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  localparam int ARB_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between fetch (instruction reads)
// and the load/store unit. Data has priority; a starvation counter forces
// a fetch grant after STARVE_LIMIT consecutive data grants while fetch waits.
//
// state      | meaning
// -----------+------------------------------------------------------
// ARB_IDLE   | no transaction outstanding; requests sampled here
// ARB_BUSY_I | fetch transaction on the memory port, awaiting mem_resp
// ARB_BUSY_D | data transaction on the memory port, awaiting mem_resp
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        arb_busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    state;
  logic [CW-1:0] starve_cnt;
  logic          drop;
  mem_req_t      mem_q;
  mem_req_t      req_i;
  mem_req_t      req_d;
  logic          ireq;
  logic          dreq;
  logic          force_i;

  assign ireq    = |imem_rmask;
  assign dreq    = (|dmem_rmask) | (|dmem_wmask);
  assign force_i = ireq && (starve_cnt == LIMIT);

  // Build the request images that get latched on a grant.
  always_comb begin
    req_i.addr  = imem_addr;
    req_i.rmask = imem_rmask;
    req_i.wmask = 4'h0;
    req_i.wdata = 32'h0;
    req_d.addr  = dmem_addr;
    // A request carrying both masks is treated as a store.
    req_d.rmask = (|dmem_wmask) ? 4'h0 : dmem_rmask;
    req_d.wmask = dmem_wmask;
    req_d.wdata = dmem_wdata;
  end

  // Response forwarding: owner sees mem_rdata and a resp pulse; a flushed
  // fetch (drop set, or mask already gone when the response lands) is silent.
  always_comb begin
    imem_resp  = (state == ARB_BUSY_I) && mem_resp && !drop && ireq;
    dmem_resp  = (state == ARB_BUSY_D) && mem_resp;
    imem_rdata = imem_resp ? mem_rdata : 32'h0;
    dmem_rdata = dmem_resp ? mem_rdata : 32'h0;
  end

  assign mem_addr  = mem_q.addr;
  assign mem_rmask = mem_q.rmask;
  assign mem_wmask = mem_q.wmask;
  assign mem_wdata = mem_q.wdata;

  // Arbitration FSM with starvation counter and registered port outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      drop       <= 1'b0;
      mem_q      <= '0;
      arb_busy   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          drop <= 1'b0;
          if (dreq && !force_i) begin
            mem_q    <= req_d;
            state    <= ARB_BUSY_D;
            arb_busy <= 1'b1;
            if (ireq && (starve_cnt != LIMIT))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (ireq) begin
            mem_q      <= req_i;
            state      <= ARB_BUSY_I;
            arb_busy   <= 1'b1;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        ARB_BUSY_I: begin
          if (mem_resp) begin
            state       <= ARB_IDLE;
            arb_busy    <= 1'b0;
            drop        <= 1'b0;
            mem_q.rmask <= 4'h0;
            mem_q.wmask <= 4'h0;
          end else if (!ireq) begin
            drop <= 1'b1;
          end
        end
        ARB_BUSY_D: begin
          if (mem_resp) begin
            state       <= ARB_IDLE;
            arb_busy    <= 1'b0;
            mem_q.rmask <= 4'h0;
            mem_q.wmask <= 4'h0;
          end
        end
        default: begin
          state    <= ARB_IDLE;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a hand-driven memory side.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr = '0;
  logic [3:0]  imem_rmask = '0;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr = '0;
  logic [3:0]  dmem_rmask = '0;
  logic [3:0]  dmem_wmask = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;
  logic        arb_busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise mem_resp for the current cycle and let combinational outputs settle.
  task automatic respond(input logic [31:0] data);
    mem_rdata = data;
    mem_resp  = 1'b1;
    #1;
  endtask

  task automatic end_resp();
    tick();
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  logic [31:0] star_addr [6];

  initial begin
    star_addr[0] = 32'h9000; star_addr[1] = 32'h9000; star_addr[2] = 32'h9000;
    star_addr[3] = 32'h9000; star_addr[4] = 32'h3000; star_addr[5] = 32'h9000;

    // Reset
    tick(); tick();
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_masks", {24'h0, mem_rmask, mem_wmask}, 32'h0);
    chk("rst_busy", {31'h0, arb_busy}, 32'h0);
    rst = 1'b1;
    tick();

    // Instruction-only read, memory answers 2 cycles after issue
    imem_addr = 32'h1000; imem_rmask = 4'hF;
    tick();
    chk("i_addr", mem_addr, 32'h1000);
    chk("i_rmask", {28'h0, mem_rmask}, 32'hF);
    chk("i_busy", {31'h0, arb_busy}, 32'h1);
    chk("i_noresp_early", {31'h0, imem_resp}, 32'h0);
    tick();
    chk("i_noresp_wait", {31'h0, imem_resp}, 32'h0);
    chk("i_held_addr", mem_addr, 32'h1000);
    tick();
    respond(32'h00000013);
    chk("i_resp", {31'h0, imem_resp}, 32'h1);
    chk("i_rdata", imem_rdata, 32'h00000013);
    chk("i_dresp", {31'h0, dmem_resp}, 32'h0);
    chk("i_drdata", dmem_rdata, 32'h0);
    end_resp();
    imem_rmask = 4'h0;
    #1;
    chk("i_resp_once", {31'h0, imem_resp}, 32'h0);
    chk("i_idle", {31'h0, arb_busy}, 32'h0);

    // Simultaneous: store wins, fetch follows after one IDLE cycle
    imem_addr = 32'h2000; imem_rmask = 4'hF;
    dmem_addr = 32'h8000; dmem_wmask = 4'h3; dmem_wdata = 32'hDEADBEEF;
    tick();
    chk("s_addr", mem_addr, 32'h8000);
    chk("s_wmask", {28'h0, mem_wmask}, 32'h3);
    chk("s_rmask", {28'h0, mem_rmask}, 32'h0);
    chk("s_wdata", mem_wdata, 32'hDEADBEEF);
    respond(32'h0);
    chk("s_dresp", {31'h0, dmem_resp}, 32'h1);
    chk("s_iresp", {31'h0, imem_resp}, 32'h0);
    end_resp();
    dmem_wmask = 4'h0; dmem_wdata = 32'h0;
    #1;
    chk("s_gap_idle", {31'h0, arb_busy}, 32'h0);
    tick();
    chk("s_f_addr", mem_addr, 32'h2000);
    chk("s_f_rmask", {28'h0, mem_rmask}, 32'hF);
    chk("s_f_wmask", {28'h0, mem_wmask}, 32'h0);
    chk("s_f_wdata", mem_wdata, 32'h0);
    respond(32'hCAFE0001);
    chk("s_f_resp", {31'h0, imem_resp}, 32'h1);
    end_resp();
    imem_rmask = 4'h0;

    // Starvation: D,D,D,D then forced I, then D resumes
    imem_addr = 32'h3000; imem_rmask = 4'hF;
    dmem_addr = 32'h9000; dmem_rmask = 4'hF;
    for (int g = 0; g < 6; g++) begin
      tick();
      chk($sformatf("starve_grant%0d", g), mem_addr, star_addr[g]);
      respond(32'h100 + g);
      chk($sformatf("starve_iresp%0d", g), {31'h0, imem_resp}, (g == 4) ? 32'h1 : 32'h0);
      end_resp();
      if (g == 4) imem_rmask = 4'h0;
    end
    dmem_rmask = 4'h0;
    tick();

    // Flush abort
    imem_addr = 32'h4000; imem_rmask = 4'hF;
    tick();
    imem_rmask = 4'h0;
    tick();
    chk("fl_held_addr", mem_addr, 32'h4000);
    chk("fl_held_rmask", {28'h0, mem_rmask}, 32'hF);
    tick();
    imem_rmask = 4'hF; imem_addr = 32'h4444;
    respond(32'hBAD0BAD0);
    chk("fl_no_resp", {31'h0, imem_resp}, 32'h0);
    chk("fl_no_rdata", imem_rdata, 32'h0);
    end_resp();
    imem_addr = 32'h5000;
    tick();
    chk("fl_next_addr", mem_addr, 32'h5000);
    respond(32'h00C0FFEE);
    chk("fl_next_resp", {31'h0, imem_resp}, 32'h1);
    chk("fl_next_rdata", imem_rdata, 32'h00C0FFEE);
    end_resp();
    imem_rmask = 4'h0;

    // Both masks set: issued as a store
    dmem_addr = 32'hA000; dmem_rmask = 4'hF; dmem_wmask = 4'hF; dmem_wdata = 32'h12345678;
    tick();
    chk("b_wmask", {28'h0, mem_wmask}, 32'hF);
    chk("b_rmask", {28'h0, mem_rmask}, 32'h0);
    respond(32'h0);
    chk("b_dresp", {31'h0, dmem_resp}, 32'h1);
    end_resp();
    dmem_rmask = 4'h0; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
    tick();

    // Reset mid-transaction; late mem_resp ignored
    dmem_addr = 32'hB000; dmem_rmask = 4'hF;
    tick();
    chk("r_busy_before", {31'h0, arb_busy}, 32'h1);
    rst = 1'b0;
    tick();
    dmem_rmask = 4'h0;
    chk("r_addr", mem_addr, 32'h0);
    chk("r_masks", {24'h0, mem_rmask, mem_wmask}, 32'h0);
    chk("r_busy", {31'h0, arb_busy}, 32'h0);
    rst = 1'b1;
    tick();
    respond(32'h77777777);
    chk("r_late_dresp", {31'h0, dmem_resp}, 32'h0);
    chk("r_late_drdata", dmem_rdata, 32'h0);
    end_resp();
    chk("r_still_idle", {31'h0, arb_busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one unified memory port between the fetch stage (instruction reads) and the load/store functional unit (data reads and writes). The instruction and data requesters use the same mask/resp handshake as the CPU memory interfaces. Data requests have priority, and a starvation counter guarantees forward progress for fetch. Fetch requests killed by a branch flush are completed on the memory side and their responses discarded.

## Interface
Parameters:
- STARVE_LIMIT, default 4: number of consecutive data grants allowed while an instruction request is waiting; the next grant is then forced to the instruction side.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- imem_addr  in  32  fetch address
- imem_rmask  in  4  fetch read mask; nonzero = request
- imem_rdata  out  32  fetch read data
- imem_resp  out  1  fetch response pulse
- dmem_addr  in  32  data address
- dmem_rmask  in  4  load mask; nonzero = load request
- dmem_wmask  in  4  store mask; nonzero = store request
- dmem_wdata  in  32  store data
- dmem_rdata  out  32  load data
- dmem_resp  out  1  data response pulse
- mem_addr  out  32  unified memory address
- mem_rmask  out  4  unified read mask
- mem_wmask  out  4  unified write mask
- mem_wdata  out  32  unified write data
- mem_rdata  in  32  unified read data
- mem_resp  in  1  unified response; one-cycle pulse
- arb_busy  out  1  a transaction is outstanding

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE with a data request (rmask or wmask nonzero):
  - Grant data, unless starve_cnt == STARVE_LIMIT and an instruction request is pending.
  - Granting data while an instruction request waits increments starve_cnt, saturating at STARVE_LIMIT.
- IDLE with only an instruction request, or a forced instruction grant:
  - Grant the instruction side.
  - Clear starve_cnt.
- IDLE with no request: starve_cnt clears.
- On grant:
  - Latch addr, rmask, wmask and wdata into output registers.
  - Move to BUSY_I or BUSY_D.
  - Hold the mem_* outputs stable until mem_resp.
- A data request with both masks nonzero is issued as a store: wmask is kept and mem_rmask is forced to 0.
- Instruction grants always drive mem_wmask = 0 and mem_wdata = 0.
- In BUSY_x, mem_resp forwards mem_rdata to the owner's rdata and pulses the owner's resp in the same cycle, combinationally.
- In BUSY_x, on mem_resp the state returns to IDLE and the mem_* mask registers clear to 0.
- Flush abort:
  - In BUSY_I, imem_rmask dropping to 0 before mem_resp sets a drop flag.
  - When mem_resp arrives with drop set: imem_resp stays 0, drop clears, and the state returns to IDLE.
  - The memory-side transaction is never cancelled.
- A data requester dropping its masks in BUSY_D is a protocol violation. The latched transaction completes and dmem_resp still pulses.
- mem_resp in IDLE is ignored.
- rdata outputs to the non-owner are 0.

## Timing
- Reset values (rst == 0 at a clk edge):
  - state IDLE, starve_cnt 0, drop 0.
  - mem_addr, mem_rmask, mem_wmask and mem_wdata all 0.
  - imem_resp, dmem_resp and arb_busy 0; rdata outputs 0.
- Reset mid-transaction abandons the transaction. A later mem_resp arrives in IDLE and is ignored.
- Request seen in IDLE at cycle t: mem_* is valid from cycle t+1.
- With a zero-wait memory (mem_resp at t+1), the requester's resp fires at t+1.
- Minimum turnaround: one IDLE cycle between transactions, so back-to-back throughput is one transaction per 2 cycles with a zero-wait memory.
- Requesters hold their request inputs until resp.
- In the resp cycle, request inputs are ignored. The new request is sampled in the following IDLE cycle.
- arb_busy = (state != IDLE), registered.
- Simultaneous requests in IDLE: data wins unless starvation is forced.
- starve_cnt width is $clog2(STARVE_LIMIT+1).

## Structure
- rv32i_types holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D}.
  - typedef mem_req_t with fields addr, rmask, wmask, wdata.
  - localparam ARB_STARVE_LIMIT = 4.
- Single flat module; no sub-module is warranted.
- cpu instantiates this block between fetch/fu_load_store and a single top-level memory port.

## Test plan
- Instruction-only read:
  - Stimulus: imem_addr 0x1000, rmask 0xF; memory responds 2 cycles after issue with 0x00000013.
  - Required: mem_addr 0x1000 from t+1; imem_rdata 0x00000013 with imem_resp pulsing once; dmem_resp stays 0.
- Simultaneous requests:
  - Stimulus: imem 0x2000 and a dmem store to 0x8000, wmask 0x3, wdata 0xDEADBEEF.
  - Required: the store issues first with mem_rmask 0; the fetch issues in the IDLE cycle after dmem_resp.
- Starvation:
  - Stimulus: continuous dmem loads plus one waiting fetch, STARVE_LIMIT 4.
  - Required: exactly 4 data grants, then the fetch grant, then data resumes.
- Flush abort:
  - Stimulus: fetch granted, imem_rmask dropped to 0 before mem_resp.
  - Required: mem_* held until mem_resp; no imem_resp pulse; next request accepted normally.
- Both masks set:
  - Stimulus: dmem_rmask 0xF with wmask 0xF.
  - Required: mem_wmask 0xF and mem_rmask 0.
- Reset mid-operation:
  - Stimulus: rst low during BUSY_D; mem_resp arrives after release.
  - Required: all outputs 0 and arb_busy 0; the late mem_resp produces no dmem_resp.
